// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two cache memory ports, the arbiter and physical memory.
// The slave modport is the arbiter's view. The master modport is the caches-plus-memory view.
interface cache_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  i_read;
    logic                  i_write;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [LINE_WIDTH-1:0] i_wdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic                  d_resp;

    logic [LINE_WIDTH-1:0] rdata;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_addr;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        input  d_read, d_write, d_addr, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_resp, d_resp, rdata,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport master (
        output i_read, i_write, i_addr, i_wdata,
        output d_read, d_write, d_addr, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_resp, d_resp, rdata,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between the
// instruction cache and the data cache, with grant status and wait counters.
module cache_arbiter (
    input  logic                clk,
    input  logic                rst,
    cache_arbiter_if.slave      bus,
    output logic                data_state,
    output logic                instr_state,
    output logic [31:0]         i_wait_cycles,
    output logic [31:0]         d_wait_cycles
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 0 = I, 1 = D
    logic [31:0] i_wait_q, i_wait_d;
    logic [31:0] d_wait_q, d_wait_d;

    logic i_pend;
    logic d_pend;

    assign i_pend = bus.i_read | bus.i_write;
    assign d_pend = bus.d_read | bus.d_write;

    // Memory read line is broadcast unconditionally; each cache qualifies it with its own resp.
    assign bus.rdata = bus.pmem_rdata;

    // Grant flags are held low while reset is asserted so nothing leaks mid-reset.
    assign data_state    = (state_q == GRANT_D) && !rst;
    assign instr_state   = (state_q == GRANT_I) && !rst;
    assign i_wait_cycles = i_wait_q;
    assign d_wait_cycles = d_wait_q;

    // State, fairness flag and counters register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            i_wait_q     <= '0;
            d_wait_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            i_wait_q     <= i_wait_d;
            d_wait_q     <= d_wait_d;
        end
    end

    // Next-state selection and forwarding of the granted requester to memory.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_addr  = '0;
        bus.pmem_wdata = '0;
        bus.i_resp     = 1'b0;
        bus.d_resp     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On a tie the requester not granted last time wins.
                if (i_pend && d_pend) begin
                    if (last_grant_q) begin
                        state_d      = GRANT_I;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = GRANT_D;
                        last_grant_d = 1'b1;
                    end
                end else if (i_pend) begin
                    state_d      = GRANT_I;
                    last_grant_d = 1'b0;
                end else if (d_pend) begin
                    state_d      = GRANT_D;
                    last_grant_d = 1'b1;
                end
            end
            GRANT_I: begin
                if (!i_pend) begin
                    state_d = IDLE;    // requester withdrew: abort, no resp
                end else begin
                    bus.pmem_write = bus.i_write;
                    bus.pmem_read  = bus.i_read & ~bus.i_write;
                    bus.pmem_addr  = bus.i_addr;
                    bus.pmem_wdata = bus.i_wdata;
                    if (bus.pmem_resp) begin
                        bus.i_resp = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            GRANT_D: begin
                if (!d_pend) begin
                    state_d = IDLE;
                end else begin
                    bus.pmem_write = bus.d_write;
                    bus.pmem_read  = bus.d_read & ~bus.d_write;
                    bus.pmem_addr  = bus.d_addr;
                    bus.pmem_wdata = bus.d_wdata;
                    if (bus.pmem_resp) begin
                        bus.d_resp = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A transaction caught by reset must not complete or keep memory busy.
        if (rst) begin
            bus.pmem_read  = 1'b0;
            bus.pmem_write = 1'b0;
            bus.pmem_addr  = '0;
            bus.pmem_wdata = '0;
            bus.i_resp     = 1'b0;
            bus.d_resp     = 1'b0;
        end
    end

    // Saturating wait counters: a pending requester that does not hold the grant is waiting.
    always_comb begin
        i_wait_d = i_wait_q;
        d_wait_d = d_wait_q;
        if (i_pend && (state_q != GRANT_I) && (i_wait_q != 32'hFFFF_FFFF))
            i_wait_d = i_wait_q + 32'd1;
        if (d_pend && (state_q != GRANT_D) && (d_wait_q != 32'hFFFF_FFFF))
            d_wait_d = d_wait_q + 32'd1;
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;
    logic        clk;
    logic        rst;
    logic        data_state;
    logic        instr_state;
    logic [31:0] i_wait_cycles;
    logic [31:0] d_wait_cycles;

    int checks   = 0;
    int failures = 0;

    cache_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus ();

    cache_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .data_state    (data_state),
        .instr_state   (instr_state),
        .i_wait_cycles (i_wait_cycles),
        .d_wait_cycles (d_wait_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [255:0] pat;
    logic [255:0] aa;

    initial begin
        pat = {8{32'hC0DE_0000}} ^ 256'h1234_5678;
        aa  = {32{8'hAA}};

        rst            = 1'b1;
        bus.i_read     = 1'b0;
        bus.i_write    = 1'b0;
        bus.i_addr     = '0;
        bus.i_wdata    = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;

        // ---------------- reset state
        tick();
        tick();
        #1;
        chk("rst_pmem_read", bus.pmem_read, 1'b0);
        chk("rst_i_resp", bus.i_resp, 1'b0);
        chk("rst_data_state", data_state, 1'b0);
        chk("rst_instr_state", instr_state, 1'b0);
        rst = 1'b0;
        tick();
        #1;
        chk("rst_i_wait", i_wait_cycles, 32'd0);
        chk("rst_d_wait", d_wait_cycles, 32'd0);
        chk("rst_pmem_addr", bus.pmem_addr, 32'd0);

        // ---------------- I-only read, resp in 3rd grant cycle
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_1000;
        #1;
        chk("t1_idle_pmem_read", bus.pmem_read, 1'b0);
        chk("t1_idle_instr_state", instr_state, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = pat;
            end
            #1;
            chk("t1_pmem_read", bus.pmem_read, 1'b1);
            chk("t1_pmem_addr", bus.pmem_addr, 32'h0000_1000);
            chk("t1_instr_state", instr_state, 1'b1);
            chk("t1_d_resp", bus.d_resp, 1'b0);
            chk("t1_i_resp", bus.i_resp, (c == 2) ? 1'b1 : 1'b0);
        end
        chk("t1_rdata", bus.rdata, pat);
        tick();
        bus.i_read    = 1'b0;
        bus.pmem_resp = 1'b0;
        #1;
        chk("t1_after_i_resp", bus.i_resp, 1'b0);
        chk("t1_after_instr_state", instr_state, 1'b0);
        chk("t1_after_pmem_read", bus.pmem_read, 1'b0);
        chk("t1_i_wait", i_wait_cycles, 32'd1);
        chk("t1_d_wait", d_wait_cycles, 32'd0);

        // ---------------- simultaneous I and D after reset: D first
        do_reset();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_2000;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_3000;
        #1;
        chk("t2_i_wait0", i_wait_cycles, 32'd0);
        tick();
        #1;
        chk("t2_data_state", data_state, 1'b1);
        chk("t2_instr_state", instr_state, 1'b0);
        chk("t2_pmem_addr_d", bus.pmem_addr, 32'h0000_3000);
        chk("t2_i_wait1", i_wait_cycles, 32'd1);
        chk("t2_d_wait1", d_wait_cycles, 32'd1);
        tick();
        bus.pmem_resp = 1'b1;
        #1;
        chk("t2_d_resp", bus.d_resp, 1'b1);
        chk("t2_i_resp_low", bus.i_resp, 1'b0);
        tick();
        bus.d_read    = 1'b0;
        bus.pmem_resp = 1'b0;
        #1;
        chk("t2_idle_data_state", data_state, 1'b0);
        chk("t2_idle_pmem_read", bus.pmem_read, 1'b0);
        chk("t2_i_wait3", i_wait_cycles, 32'd3);
        tick();
        #1;
        chk("t2_instr_state", instr_state, 1'b1);
        chk("t2_pmem_addr_i", bus.pmem_addr, 32'h0000_2000);
        chk("t2_i_wait_final", i_wait_cycles, 32'd4);
        chk("t2_d_wait_final", d_wait_cycles, 32'd1);
        bus.pmem_resp = 1'b1;
        #1;
        chk("t2_i_resp", bus.i_resp, 1'b1);
        tick();
        bus.i_read    = 1'b0;
        bus.pmem_resp = 1'b0;

        // ---------------- four back-to-back ties: D, I, D, I
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        for (int r = 0; r < 4; r++) begin
            #1;
            chk("t3_idle_data_state", data_state, 1'b0);
            chk("t3_idle_instr_state", instr_state, 1'b0);
            tick();
            bus.pmem_resp = 1'b1;
            #1;
            chk("t3_data_state", data_state, (r % 2 == 0) ? 1'b1 : 1'b0);
            chk("t3_instr_state", instr_state, (r % 2 == 1) ? 1'b1 : 1'b0);
            chk("t3_d_resp", bus.d_resp, (r % 2 == 0) ? 1'b1 : 1'b0);
            chk("t3_i_resp", bus.i_resp, (r % 2 == 1) ? 1'b1 : 1'b0);
            tick();
            bus.pmem_resp = 1'b0;
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        tick();

        // ---------------- D write-back, then I read, then D read
        bus.d_write = 1'b1;
        bus.d_read  = 1'b1;
        bus.d_addr  = 32'h0000_4000;
        bus.d_wdata = aa;
        bus.i_read  = 1'b1;
        bus.i_addr  = 32'h0000_5000;
        tick();
        #1;
        chk("t4_wb_data_state", data_state, 1'b1);
        chk("t4_wb_pmem_write", bus.pmem_write, 1'b1);
        chk("t4_wb_pmem_read", bus.pmem_read, 1'b0);
        chk("t4_wb_pmem_addr", bus.pmem_addr, 32'h0000_4000);
        chk("t4_wb_pmem_wdata", bus.pmem_wdata, aa);
        bus.pmem_resp = 1'b1;
        #1;
        chk("t4_wb_d_resp", bus.d_resp, 1'b1);
        tick();
        bus.d_write   = 1'b0;
        bus.d_addr    = 32'h0000_4400;
        bus.pmem_resp = 1'b0;
        tick();
        #1;
        chk("t4_i_instr_state", instr_state, 1'b1);
        chk("t4_i_pmem_read", bus.pmem_read, 1'b1);
        chk("t4_i_pmem_addr", bus.pmem_addr, 32'h0000_5000);
        chk("t4_i_pmem_wdata", bus.pmem_wdata, 256'd0);
        bus.pmem_resp = 1'b1;
        #1;
        chk("t4_i_resp", bus.i_resp, 1'b1);
        tick();
        bus.i_read    = 1'b0;
        bus.pmem_resp = 1'b0;
        tick();
        #1;
        chk("t4_fill_data_state", data_state, 1'b1);
        chk("t4_fill_pmem_read", bus.pmem_read, 1'b1);
        chk("t4_fill_pmem_write", bus.pmem_write, 1'b0);
        chk("t4_fill_pmem_addr", bus.pmem_addr, 32'h0000_4400);
        bus.pmem_resp = 1'b1;
        #1;
        chk("t4_fill_d_resp", bus.d_resp, 1'b1);
        tick();
        bus.d_read    = 1'b0;
        bus.pmem_resp = 1'b0;
        tick();

        // ---------------- reset during GRANT_I before resp
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_6000;
        tick();
        #1;
        chk("t5_instr_state", instr_state, 1'b1);
        chk("t5_pmem_read", bus.pmem_read, 1'b1);
        chk("t5_d_wait_nonzero", (d_wait_cycles != 32'd0), 1'b1);
        rst           = 1'b1;
        bus.pmem_resp = 1'b1;
        #1;
        chk("t5_rst_i_resp", bus.i_resp, 1'b0);
        chk("t5_rst_pmem_read", bus.pmem_read, 1'b0);
        tick();
        rst           = 1'b0;
        bus.pmem_resp = 1'b0;
        bus.i_read    = 1'b0;
        #1;
        chk("t5_after_instr_state", instr_state, 1'b0);
        chk("t5_after_pmem_read", bus.pmem_read, 1'b0);
        chk("t5_after_i_resp", bus.i_resp, 1'b0);
        chk("t5_after_i_wait", i_wait_cycles, 32'd0);
        chk("t5_after_d_wait", d_wait_cycles, 32'd0);

        // ---------------- D aborts mid-grant, stray resp afterwards
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_7000;
        tick();
        #1;
        chk("t6_data_state", data_state, 1'b1);
        chk("t6_pmem_addr", bus.pmem_addr, 32'h0000_7000);
        tick();
        bus.d_read = 1'b0;
        #1;
        chk("t6_abort_pmem_read", bus.pmem_read, 1'b0);
        chk("t6_abort_d_resp", bus.d_resp, 1'b0);
        tick();
        bus.pmem_resp = 1'b1;
        #1;
        chk("t6_stray_d_resp", bus.d_resp, 1'b0);
        chk("t6_stray_i_resp", bus.i_resp, 1'b0);
        chk("t6_stray_data_state", data_state, 1'b0);
        tick();
        bus.pmem_resp = 1'b0;
        #1;
        chk("t6_idle_data_state", data_state, 1'b0);
        chk("t6_idle_instr_state", instr_state, 1'b0);
        chk("t6_d_wait", d_wait_cycles, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
